// File: rtl/sddr_pkg.sv
// rtl/sddr_pkg.sv - shared encodings, state types and helpers for the DDR3 bank scheduler
package sddr_pkg;

    localparam int CNT_W   = 16;
    localparam int A10_BIT = 10;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    typedef enum logic {
        BANK_IDLE,
        BANK_ACTIVE
    } bank_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_COL,
        S_REF_PREA,
        S_REF
    } req_state_t;

    // Column onto the address pins: A10 is reserved for auto-precharge, so
    // column bits 10 and up shift to A11 and above.
    function automatic logic [31:0] col_to_addr(input logic [30:0] col);
        return {col[30:10], 1'b0, col[9:0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

endpackage

// File: rtl/sddr_bank_tracker.sv
// rtl/sddr_bank_tracker.sv - open-row state and timing eligibility for one DDR3 bank
module sddr_bank_tracker
    import sddr_pkg::*;
#(
    parameter int ROW_BITS = 13,
    parameter int tRCD     = 5,
    parameter int tRP      = 5,
    parameter int tRAS     = 14,
    parameter int tWR      = 10,
    parameter int tRFC     = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ROW_BITS-1:0] row,
    input  logic                act,
    input  logic                pre,
    input  logic                col,
    input  logic                col_write,
    input  logic                refresh,
    output logic                hit,
    output logic                open,
    output logic                act_ok,
    output logic                col_ok,
    output logic                pre_ok
);

    bank_state_t         state_q;
    logic [ROW_BITS-1:0] row_q;
    logic [CNT_W-1:0]    act_cnt;
    logic [CNT_W-1:0]    col_cnt;
    logic [CNT_W-1:0]    pre_cnt;
    logic [CNT_W-1:0]    pre_dec;

    assign pre_dec = sat_dec(pre_cnt);
    assign open    = (state_q == BANK_ACTIVE);
    assign hit     = open && (row_q == row);
    assign act_ok  = (act_cnt == '0);
    assign col_ok  = (col_cnt == '0);
    assign pre_ok  = (pre_cnt == '0);

    // Counters hold (gap - 1) at the issue edge so that zero means the gap is met.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BANK_IDLE;
            row_q   <= '0;
            act_cnt <= '0;
            col_cnt <= '0;
            pre_cnt <= '0;
        end else begin
            if (refresh)
                act_cnt <= CNT_W'(tRFC - 1);
            else if (pre)
                act_cnt <= CNT_W'(tRP - 1);
            else
                act_cnt <= sat_dec(act_cnt);

            if (act)
                col_cnt <= CNT_W'(tRCD - 1);
            else
                col_cnt <= sat_dec(col_cnt);

            // A write extends the precharge hold but never shortens a pending tRAS.
            if (act)
                pre_cnt <= CNT_W'(tRAS - 1);
            else if (col && col_write && (pre_dec < CNT_W'(tWR - 1)))
                pre_cnt <= CNT_W'(tWR - 1);
            else
                pre_cnt <= pre_dec;

            if (act) begin
                state_q <= BANK_ACTIVE;
                row_q   <= row;
            end else if (pre) begin
                state_q <= BANK_IDLE;
            end
        end
    end

endmodule

// File: rtl/sddr_bank_scheduler.sv
// rtl/sddr_bank_scheduler.sv - open-page DDR3 command scheduler with periodic refresh
module sddr_bank_scheduler
    import sddr_pkg::*;
#(
    parameter int BANK_BITS = 3,
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 10,
    parameter int tRCD      = 5,
    parameter int tRP       = 5,
    parameter int tRAS      = 14,
    parameter int tWR       = 10,
    parameter int tCCD      = 4,
    parameter int tRFC      = 64,
    parameter int tREFI     = 3120
) (
    input  logic                                  ddr_clock_i,
    input  logic                                  ddr_reset_i,
    input  logic                                  enable_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic                                  req_write_i,
    input  logic [BANK_BITS+ROW_BITS+COL_BITS-1:0] req_addr_i,
    output logic [3:0]                            cmd_o,
    output logic [BANK_BITS-1:0]                  cmd_ba_o,
    output logic [ROW_BITS-1:0]                   cmd_addr_o,
    output logic                                  xfer_start_o,
    output logic                                  xfer_write_o,
    output logic                                  refresh_busy_o,
    output logic                                  refresh_overdue_o
);

    localparam int NB = 1 << BANK_BITS;
    localparam int AW = BANK_BITS + ROW_BITS + COL_BITS;

    logic [BANK_BITS-1:0] req_bank, lat_bank, cur_bank;
    logic [ROW_BITS-1:0]  req_row, lat_row, cur_row;
    logic [COL_BITS-1:0]  req_col, lat_col;
    logic                 lat_write;

    req_state_t           state_q, state_d;
    logic [3:0]           cmd_d;
    logic [BANK_BITS-1:0] ba_d;
    logic [ROW_BITS-1:0]  addr_d;
    logic                 xfer_start_d, xfer_write_d, ready_d;
    logic                 accept, do_act, do_pre, do_prea, do_col, do_ref, pending_clr;
    logic                 pending_q, pending_d, overdue_q, refi_expire;
    logic [CNT_W-1:0]     ccd_cnt, rfc_cnt, refi_cnt;

    logic [NB-1:0] hit_v, open_v, act_ok_v, col_ok_v, pre_ok_v;
    logic [NB-1:0] act_v, pre_v, col_v;

    assign req_bank = req_addr_i[AW-1 -: BANK_BITS];
    assign req_row  = req_addr_i[ROW_BITS+COL_BITS-1 -: ROW_BITS];
    assign req_col  = req_addr_i[COL_BITS-1:0];

    // Idle compares against the incoming request; later states work on the latched one.
    assign cur_bank = (state_q == S_IDLE) ? req_bank : lat_bank;
    assign cur_row  = (state_q == S_IDLE) ? req_row  : lat_row;

    assign refi_expire = (refi_cnt == '0);

    // Fan the single issued command out to the bank it targets.
    always_comb begin
        act_v = '0;
        pre_v = '0;
        col_v = '0;
        for (int b = 0; b < NB; b++) begin
            act_v[b] = do_act && (lat_bank == BANK_BITS'(b));
            pre_v[b] = do_prea || (do_pre && (lat_bank == BANK_BITS'(b)));
            col_v[b] = do_col && (lat_bank == BANK_BITS'(b));
        end
    end

    generate
        for (genvar b = 0; b < NB; b++) begin : g_bank
            sddr_bank_tracker #(
                .ROW_BITS (ROW_BITS),
                .tRCD     (tRCD),
                .tRP      (tRP),
                .tRAS     (tRAS),
                .tWR      (tWR),
                .tRFC     (tRFC)
            ) u_tracker (
                .clk       (ddr_clock_i),
                .rst       (ddr_reset_i),
                .row       (cur_row),
                .act       (act_v[b]),
                .pre       (pre_v[b]),
                .col       (col_v[b]),
                .col_write (lat_write),
                .refresh   (do_ref),
                .hit       (hit_v[b]),
                .open      (open_v[b]),
                .act_ok    (act_ok_v[b]),
                .col_ok    (col_ok_v[b]),
                .pre_ok    (pre_ok_v[b])
            );
        end
    endgenerate

    // Request/refresh FSM: next state and the command to drive on the next edge.
    always_comb begin
        state_d      = state_q;
        cmd_d        = CMD_NOP;
        ba_d         = '0;
        addr_d       = '0;
        xfer_start_d = 1'b0;
        xfer_write_d = 1'b0;
        do_act       = 1'b0;
        do_pre       = 1'b0;
        do_prea      = 1'b0;
        do_col       = 1'b0;
        do_ref       = 1'b0;
        pending_clr  = 1'b0;
        accept       = req_valid_i && req_ready_o && (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (hit_v[cur_bank])
                        state_d = S_COL;
                    else if (open_v[cur_bank])
                        state_d = S_PRE;
                    else
                        state_d = S_ACT;
                end else if (pending_q) begin
                    state_d = S_REF_PREA;
                end
            end
            S_PRE: begin
                if (pre_ok_v[lat_bank]) begin
                    cmd_d   = CMD_PRE;
                    ba_d    = lat_bank;
                    do_pre  = 1'b1;
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                if (act_ok_v[lat_bank]) begin
                    cmd_d   = CMD_ACT;
                    ba_d    = lat_bank;
                    addr_d  = lat_row;
                    do_act  = 1'b1;
                    state_d = S_COL;
                end
            end
            S_COL: begin
                if (col_ok_v[lat_bank] && (ccd_cnt == '0)) begin
                    cmd_d        = lat_write ? CMD_WR : CMD_RD;
                    ba_d         = lat_bank;
                    addr_d       = ROW_BITS'(col_to_addr(31'(lat_col)));
                    xfer_start_d = 1'b1;
                    xfer_write_d = lat_write;
                    do_col       = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_REF_PREA: begin
                if (|open_v) begin
                    if (&pre_ok_v) begin
                        cmd_d           = CMD_PRE;
                        addr_d[A10_BIT] = 1'b1;
                        do_prea         = 1'b1;
                    end
                end else if (&act_ok_v) begin
                    cmd_d   = CMD_REF;
                    do_ref  = 1'b1;
                    state_d = S_REF;
                end
            end
            S_REF: begin
                if (rfc_cnt == '0) begin
                    pending_clr = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh expiry wins over the clear so a back-to-back interval is not lost.
        pending_d = pending_q;
        if (pending_clr)
            pending_d = 1'b0;
        if (refi_expire)
            pending_d = 1'b1;

        ready_d = enable_i && !pending_d && (state_d == S_IDLE);
    end

    // FSM state and registered command/handshake outputs.
    always_ff @(posedge ddr_clock_i or posedge ddr_reset_i) begin
        if (ddr_reset_i) begin
            state_q      <= S_IDLE;
            cmd_o        <= CMD_NOP;
            cmd_ba_o     <= '0;
            cmd_addr_o   <= '0;
            xfer_start_o <= 1'b0;
            xfer_write_o <= 1'b0;
            req_ready_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_o        <= cmd_d;
            cmd_ba_o     <= ba_d;
            cmd_addr_o   <= addr_d;
            xfer_start_o <= xfer_start_d;
            xfer_write_o <= xfer_write_d;
            req_ready_o  <= ready_d;
        end
    end

    // Capture the accepted request for the PRE/ACT/column sequence.
    always_ff @(posedge ddr_clock_i or posedge ddr_reset_i) begin
        if (ddr_reset_i) begin
            lat_bank  <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
            lat_write <= 1'b0;
        end else if (accept) begin
            lat_bank  <= req_bank;
            lat_row   <= req_row;
            lat_col   <= req_col;
            lat_write <= req_write_i;
        end
    end

    // Global column spacing, refresh recovery and refresh interval timers.
    always_ff @(posedge ddr_clock_i or posedge ddr_reset_i) begin
        if (ddr_reset_i) begin
            ccd_cnt   <= '0;
            rfc_cnt   <= '0;
            refi_cnt  <= CNT_W'(tREFI);
            pending_q <= 1'b0;
            overdue_q <= 1'b0;
        end else begin
            ccd_cnt   <= do_col ? CNT_W'(tCCD - 1) : sat_dec(ccd_cnt);
            rfc_cnt   <= do_ref ? CNT_W'(tRFC - 1) : sat_dec(rfc_cnt);
            refi_cnt  <= refi_expire ? CNT_W'(tREFI) : refi_cnt - CNT_W'(1);
            pending_q <= pending_d;
            if (refi_expire && pending_q)
                overdue_q <= 1'b1;
        end
    end

    assign refresh_busy_o    = pending_q;
    assign refresh_overdue_o = overdue_q;

endmodule

// File: tb/tb_sddr_bank_scheduler.sv
// tb/tb_sddr_bank_scheduler.sv - directed self-checking bench for sddr_bank_scheduler
module tb_sddr_bank_scheduler;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [25:0] req_addr = '0;
    logic        req_ready;
    logic [3:0]  cmd;
    logic [2:0]  cmd_ba;
    logic [12:0] cmd_addr;
    logic        xfer_start, xfer_write, ref_busy, ref_overdue;

    logic        b_ready, b_xs, b_xw, b_busy, b_overdue;
    logic [3:0]  b_cmd;
    logic [2:0]  b_ba;
    logic [12:0] b_addr;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int r0, act_at, rd_at, wr_at, acc, expv;

    int          w_at;
    logic [3:0]  w_cmd;
    logic [2:0]  w_ba;
    logic [12:0] w_addr;
    logic        w_xs, w_xw;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sddr_bank_scheduler #(.tREFI(100)) u_dut (
        .ddr_clock_i(clk), .ddr_reset_i(rst), .enable_i(enable),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .cmd_o(cmd), .cmd_ba_o(cmd_ba), .cmd_addr_o(cmd_addr),
        .xfer_start_o(xfer_start), .xfer_write_o(xfer_write),
        .refresh_busy_o(ref_busy), .refresh_overdue_o(ref_overdue)
    );

    sddr_bank_scheduler #(.tREFI(50)) u_dut_fast_refi (
        .ddr_clock_i(clk), .ddr_reset_i(rst), .enable_i(1'b0),
        .req_valid_i(1'b0), .req_ready_o(b_ready), .req_write_i(1'b0),
        .req_addr_i(26'd0), .cmd_o(b_cmd), .cmd_ba_o(b_ba), .cmd_addr_o(b_addr),
        .xfer_start_o(b_xs), .xfer_write_o(b_xw),
        .refresh_busy_o(b_busy), .refresh_overdue_o(b_overdue)
    );

    task automatic do_reset();
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        r0 = cyc;
    endtask

    task automatic wait_cmd(input int limit);
        w_at = -1; w_cmd = NOP; w_ba = '0; w_addr = '0; w_xs = 1'b0; w_xw = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (cmd !== NOP) begin
                w_at = cyc; w_cmd = cmd; w_ba = cmd_ba; w_addr = cmd_addr;
                w_xs = xfer_start; w_xw = xfer_write;
                break;
            end
        end
    endtask

    task automatic send_req(input logic w, input logic [2:0] b, input logic [12:0] r,
                            input logic [9:0] c, output int at);
        logic rdy;
        req_write = w; req_addr = {b, r, c}; req_valid = 1'b1; at = -1;
        for (int i = 0; i < 300; i++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy) begin at = cyc; break; end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (cmd !== NOP) begin n_bad++; $display("FAIL reset_cmd: got %b want %b", cmd, NOP); end
        n_cmp++; if ({cmd_ba, cmd_addr} !== 16'd0) begin n_bad++; $display("FAIL reset_ba_addr: got %h want 0", {cmd_ba, cmd_addr}); end
        n_cmp++; if ({req_ready, xfer_start, xfer_write, ref_busy, ref_overdue} !== 5'd0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {req_ready, xfer_start, xfer_write, ref_busy, ref_overdue}); end
    endtask

    task automatic test_cold_read();
        do_reset();
        send_req(1'b0, 3'd2, 13'h15, 10'h40, acc);
        enable = 1'b0;
        wait_cmd(50);
        act_at = w_at;
        n_cmp++; if (w_cmd !== ACT || w_ba !== 3'd2 || w_addr !== 13'h15) begin n_bad++; $display("FAIL cold_act: got %b/%0d/%h want %b/2/15", w_cmd, w_ba, w_addr, ACT); end
        n_cmp++; if (w_at !== acc + 1) begin n_bad++; $display("FAIL cold_act_cycle: got %0d want %0d", w_at, acc + 1); end
        wait_cmd(50);
        rd_at = w_at;
        n_cmp++; if (w_cmd !== RD || w_ba !== 3'd2 || w_addr !== 13'h040) begin n_bad++; $display("FAIL cold_rd: got %b/%0d/%h want %b/2/040", w_cmd, w_ba, w_addr, RD); end
        n_cmp++; if (w_at !== acc + 6) begin n_bad++; $display("FAIL cold_rd_cycle: got %0d want %0d", w_at, acc + 6); end
        n_cmp++; if (w_xs !== 1'b1 || w_xw !== 1'b0) begin n_bad++; $display("FAIL cold_xfer: got %b%b want 10", w_xs, w_xw); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL disabled_ready: got %b want 0", req_ready); end
        enable = 1'b1;
    endtask

    task automatic test_row_hit();
        send_req(1'b1, 3'd2, 13'h15, 10'h44, acc);
        expv = (acc + 1 > rd_at + 4) ? acc + 1 : rd_at + 4;
        wait_cmd(50);
        wr_at = w_at;
        n_cmp++; if (w_cmd !== WR || w_ba !== 3'd2 || w_addr !== 13'h044) begin n_bad++; $display("FAIL hit_wr: got %b/%0d/%h want %b/2/044", w_cmd, w_ba, w_addr, WR); end
        n_cmp++; if (w_at !== expv) begin n_bad++; $display("FAIL hit_wr_cycle: got %0d want %0d", w_at, expv); end
        n_cmp++; if (w_xs !== 1'b1 || w_xw !== 1'b1) begin n_bad++; $display("FAIL hit_xfer: got %b%b want 11", w_xs, w_xw); end
    endtask

    task automatic test_row_miss();
        send_req(1'b0, 3'd2, 13'h16, 10'h80, acc);
        expv = acc + 1;
        if (act_at + 14 > expv) expv = act_at + 14;
        if (wr_at + 10 > expv) expv = wr_at + 10;
        wait_cmd(60);
        n_cmp++; if (w_cmd !== PRE || w_ba !== 3'd2 || w_addr[10] !== 1'b0) begin n_bad++; $display("FAIL miss_pre: got %b/%0d/a10=%b want %b/2/0", w_cmd, w_ba, w_addr[10], PRE); end
        n_cmp++; if (w_at !== expv) begin n_bad++; $display("FAIL miss_pre_cycle: got %0d want %0d", w_at, expv); end
        expv = w_at + 5;
        wait_cmd(60);
        n_cmp++; if (w_cmd !== ACT || w_addr !== 13'h16 || w_at !== expv) begin n_bad++; $display("FAIL miss_act: got %b/%h@%0d want %b/16@%0d", w_cmd, w_addr, w_at, ACT, expv); end
        expv = w_at + 5;
        wait_cmd(60);
        n_cmp++; if (w_cmd !== RD || w_addr !== 13'h080 || w_at !== expv) begin n_bad++; $display("FAIL miss_rd: got %b/%h@%0d want %b/080@%0d", w_cmd, w_addr, w_at, RD, expv); end
    endtask

    task automatic test_bank_parallel();
        do_reset();
        send_req(1'b0, 3'd2, 13'h15, 10'h40, acc);
        wait_cmd(50); wait_cmd(50);
        send_req(1'b0, 3'd5, 13'h20, 10'h08, acc);
        wait_cmd(50);
        n_cmp++; if (w_cmd !== ACT || w_ba !== 3'd5 || w_addr !== 13'h20) begin n_bad++; $display("FAIL par_act5: got %b/%0d/%h want %b/5/20", w_cmd, w_ba, w_addr, ACT); end
        wait_cmd(50);
        n_cmp++; if (w_cmd !== RD || w_ba !== 3'd5) begin n_bad++; $display("FAIL par_rd5: got %b/%0d want %b/5", w_cmd, w_ba, RD); end
        send_req(1'b0, 3'd2, 13'h15, 10'h41, acc);
        wait_cmd(50);
        n_cmp++; if (w_cmd !== RD || w_ba !== 3'd2 || w_addr !== 13'h041) begin n_bad++; $display("FAIL par_hit2: got %b/%0d/%h want %b/2/041", w_cmd, w_ba, w_addr, RD); end
    endtask

    task automatic test_refresh();
        int ref_at;
        do_reset();
        send_req(1'b0, 3'd1, 13'h11, 10'h01, acc);
        wait_cmd(50); wait_cmd(50);
        send_req(1'b0, 3'd3, 13'h33, 10'h03, acc);
        wait_cmd(50); wait_cmd(50);
        n_cmp++; if (ref_busy !== 1'b0) begin n_bad++; $display("FAIL ref_busy_early: got %b want 0", ref_busy); end
        wait_cmd(200);
        n_cmp++; if (w_cmd !== PRE || w_addr[10] !== 1'b1 || w_at !== r0 + 103) begin n_bad++; $display("FAIL ref_prea: got %b/a10=%b@%0d want %b/1@%0d", w_cmd, w_addr[10], w_at, PRE, r0 + 103); end
        n_cmp++; if (req_ready !== 1'b0 || ref_busy !== 1'b1) begin n_bad++; $display("FAIL ref_ready_busy: got %b%b want 01", req_ready, ref_busy); end
        expv = w_at + 5;
        wait_cmd(50);
        ref_at = w_at;
        n_cmp++; if (w_cmd !== REF || w_at !== expv) begin n_bad++; $display("FAIL ref_cmd: got %b@%0d want %b@%0d", w_cmd, w_at, REF, expv); end
        w_at = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (req_ready === 1'b1) begin w_at = cyc; break; end
        end
        n_cmp++; if (w_at !== ref_at + 64) begin n_bad++; $display("FAIL ref_ready_return: got %0d want %0d", w_at, ref_at + 64); end
        n_cmp++; if (ref_busy !== 1'b0) begin n_bad++; $display("FAIL ref_busy_clear: got %b want 0", ref_busy); end
        n_cmp++; if (ref_overdue !== 1'b0) begin n_bad++; $display("FAIL ref_not_overdue: got %b want 0", ref_overdue); end
        n_cmp++; if (b_overdue !== 1'b1) begin n_bad++; $display("FAIL ref_overdue_sticky: got %b want 1", b_overdue); end
        send_req(1'b0, 3'd1, 13'h11, 10'h02, acc);
        wait_cmd(50);
        n_cmp++; if (w_cmd !== ACT || w_ba !== 3'd1) begin n_bad++; $display("FAIL ref_closed_bank: got %b/%0d want %b/1", w_cmd, w_ba, ACT); end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_req(1'b0, 3'd4, 13'h33, 10'h10, acc);
        wait_cmd(50);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (cmd !== NOP || xfer_start !== 1'b0) begin n_bad++; $display("FAIL arst_cmd: got %b/%b want %b/0", cmd, xfer_start, NOP); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_cmd(12);
        n_cmp++; if (w_at !== -1) begin n_bad++; $display("FAIL arst_no_read: got cmd %b@%0d want none", w_cmd, w_at); end
        send_req(1'b0, 3'd4, 13'h33, 10'h10, acc);
        wait_cmd(50);
        n_cmp++; if (w_cmd !== ACT || w_ba !== 3'd4 || w_addr !== 13'h33) begin n_bad++; $display("FAIL arst_reopen: got %b/%0d/%h want %b/4/33", w_cmd, w_ba, w_addr, ACT); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_row_hit();
        test_row_miss();
        test_bank_parallel();
        test_refresh();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
